// File: rtl/ro_meas_sequencer_if.sv
// rtl/ro_meas_sequencer_if.sv - stream port between the measurement sequencer and the PS data sink
interface ro_meas_sequencer_if;
  logic        data_en;
  logic [31:0] data_out;
  logic        transfer_en;
  logic        transfer_active;

  modport master (output data_en, data_out, transfer_en, input transfer_active);
  modport slave  (input data_en, data_out, transfer_en, output transfer_active);
endinterface

// File: rtl/ro_meas_sequencer.sv
// rtl/ro_meas_sequencer.sv - RO measurement sequencer: gating, counter readout streaming, done
// Optional per-round header word: define RO_SEQ_HEADER_EN.
module ro_meas_sequencer #(
  parameter int NUM_RO = 32,
  parameter int SEL_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 DECOUPLE,
  input  logic [31:0]          meas_cmd,
  input  logic [31:0]          meas_mode,
  input  logic [31:0]          meas_time,
  input  logic [31:0]          meas_readouts,
  input  logic [31:0]          meas_heatup,
  input  logic [31:0]          meas_cooldown,
  output logic                 ro_enable,
  output logic                 cnt_clear,
  output logic                 cnt_enable,
  output logic [SEL_W-1:0]     cnt_sel,
  input  logic [31:0]          cnt_value,
  ro_meas_sequencer_if.master  strm,
  output logic                 meas_done
);

`ifdef RO_SEQ_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HEATUP   = 3'd1;
  localparam logic [2:0] S_CLEAR    = 3'd2;
  localparam logic [2:0] S_MEASURE  = 3'd3;
  localparam logic [2:0] S_SEL      = 3'd4;
  localparam logic [2:0] S_EMIT     = 3'd5;
  localparam logic [2:0] S_COOLDOWN = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_RO - 1);

  logic [2:0]       state_q, state_d;
  logic             cmd0_q;
  logic             sh_mode_q, sh_mode_d;
  logic [31:0]      sh_time_q, sh_time_d;
  logic [31:0]      sh_rd_q, sh_rd_d;
  logic [31:0]      sh_heat_q, sh_heat_d;
  logic [31:0]      sh_cool_q, sh_cool_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      rnd_q, rnd_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             hdr_q, hdr_d;
  logic             data_en_q, data_en_d;
  logic [31:0]      data_out_q, data_out_d;

  logic             start;
  logic             abort;
  logic [31:0]      meas_len;
  logic             unused_bits;

  assign unused_bits = ^{meas_cmd[31:2], meas_mode[31:1]};
  assign start    = meas_cmd[0] & ~cmd0_q;
  assign abort    = meas_cmd[1] | DECOUPLE;
  assign meas_len = (sh_time_q == 32'd0) ? 32'd1 : sh_time_q;

  always_comb begin
    state_d    = state_q;
    sh_mode_d  = sh_mode_q;
    sh_time_d  = sh_time_q;
    sh_rd_d    = sh_rd_q;
    sh_heat_d  = sh_heat_q;
    sh_cool_d  = sh_cool_q;
    cyc_d      = cyc_q;
    rnd_d      = rnd_q;
    idx_d      = idx_q;
    hdr_d      = hdr_q;
    data_en_d  = 1'b0;
    data_out_d = data_out_q;
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
      hdr_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          sh_mode_d = meas_mode[0];
          sh_time_d = meas_time;
          sh_rd_d   = meas_readouts;
          sh_heat_d = meas_heatup;
          sh_cool_d = meas_cooldown;
          rnd_d     = 32'd0;
          idx_d     = '0;
          cyc_d     = 32'd1;
          if (meas_readouts == 32'd0)    state_d = S_DONE;
          else if (meas_heatup == 32'd0) state_d = S_CLEAR;
          else                           state_d = S_HEATUP;
        end
        S_HEATUP: begin
          if (cyc_q == sh_heat_q) state_d = S_CLEAR;
          else                    cyc_d   = cyc_q + 32'd1;
        end
        S_CLEAR: begin
          cyc_d   = 32'd1;
          state_d = S_MEASURE;
        end
        S_MEASURE: begin
          if (cyc_q == meas_len) begin
            state_d = S_SEL;
            idx_d   = '0;
            hdr_d   = HDR_EN;
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        S_SEL: state_d = S_EMIT;
        // cnt_sel stays on idx_q while stalled, so cnt_value keeps tracking the same counter
        S_EMIT: if (strm.transfer_active) begin
          data_en_d = 1'b1;
          if (hdr_q) begin
            data_out_d = {8'hA5, 8'(NUM_RO), rnd_q[15:0]};
            hdr_d      = 1'b0;
            state_d    = S_SEL;
          end else begin
            data_out_d = cnt_value;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (rnd_q == sh_rd_q - 32'd1) begin
                state_d = S_DONE;
              end else begin
                rnd_d   = rnd_q + 32'd1;
                cyc_d   = 32'd1;
                state_d = (sh_cool_q == 32'd0) ? S_CLEAR : S_COOLDOWN;
              end
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_SEL;
            end
          end
        end
        S_COOLDOWN: begin
          if (cyc_q == sh_cool_q) state_d = S_CLEAR;
          else                    cyc_d   = cyc_q + 32'd1;
        end
        S_DONE: if (!meas_cmd[0]) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cmd0_q     <= 1'b0;
      sh_mode_q  <= 1'b0;
      sh_time_q  <= 32'd0;
      sh_rd_q    <= 32'd0;
      sh_heat_q  <= 32'd0;
      sh_cool_q  <= 32'd0;
      cyc_q      <= 32'd0;
      rnd_q      <= 32'd0;
      idx_q      <= '0;
      hdr_q      <= 1'b0;
      data_en_q  <= 1'b0;
      data_out_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cmd0_q     <= meas_cmd[0];
      sh_mode_q  <= sh_mode_d;
      sh_time_q  <= sh_time_d;
      sh_rd_q    <= sh_rd_d;
      sh_heat_q  <= sh_heat_d;
      sh_cool_q  <= sh_cool_d;
      cyc_q      <= cyc_d;
      rnd_q      <= rnd_d;
      idx_q      <= idx_d;
      hdr_q      <= hdr_d;
      data_en_q  <= data_en_d;
      data_out_q <= data_out_d;
    end
  end

  // Gated mode lets the ROs run only while heating or counting
  always_comb begin
    if (sh_mode_q) ro_enable = (state_q == S_HEATUP) || (state_q == S_MEASURE);
    else           ro_enable = (state_q == S_HEATUP) || (state_q == S_CLEAR) ||
                               (state_q == S_MEASURE) || (state_q == S_SEL) ||
                               (state_q == S_EMIT);
  end

  assign cnt_clear        = (state_q == S_CLEAR);
  assign cnt_enable       = (state_q == S_MEASURE);
  assign cnt_sel          = idx_q;
  assign meas_done        = (state_q == S_DONE);
  assign strm.transfer_en = (state_q != S_IDLE) && (state_q != S_DONE);
  assign strm.data_en     = data_en_q;
  assign strm.data_out    = data_out_q;

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// tb/tb_ro_meas_sequencer.sv - scoreboard bench for ro_meas_sequencer with a counter-bank model
module tb_ro_meas_sequencer;
  localparam int NUM_RO = 4;
  localparam int SEL_W  = 8;
`ifdef RO_SEQ_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic             CLK = 1'b0;
  logic             RESET;
  logic             DECOUPLE;
  logic [31:0]      meas_cmd, meas_mode, meas_time, meas_readouts, meas_heatup, meas_cooldown;
  logic             ro_enable, cnt_clear, cnt_enable, meas_done;
  logic [SEL_W-1:0] cnt_sel;
  logic [31:0]      cnt_value = 32'd0;

  ro_meas_sequencer_if strm();

  ro_meas_sequencer #(.NUM_RO(NUM_RO), .SEL_W(SEL_W)) dut (
    .CLK(CLK), .RESET(RESET), .DECOUPLE(DECOUPLE),
    .meas_cmd(meas_cmd), .meas_mode(meas_mode), .meas_time(meas_time),
    .meas_readouts(meas_readouts), .meas_heatup(meas_heatup), .meas_cooldown(meas_cooldown),
    .ro_enable(ro_enable), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value), .strm(strm), .meas_done(meas_done)
  );

  always #5 CLK = ~CLK;

  // Counter bank: every clear loads a fresh per-round salt; value = {salt, selected index}
  logic [23:0] salts [64];
  logic [23:0] cur_salt = 24'd0;
  int          clr_n = 0;
  always @(posedge CLK) begin
    if (cnt_clear) begin
      cur_salt <= salts[clr_n % 64];
      clr_n    <= clr_n + 1;
    end
    cnt_value <= {cur_salt, cnt_sel};
  end

  logic [31:0] sb_q [$];
  int n_cmp = 0, n_fail = 0;
  int n_clear = 0, n_cen = 0, n_ten = 0, n_ro = 0, n_words = 0, low_run = 0;
  int exp_cool = 0;
  bit exp_mode = 1'b0;
  bit prev_ta = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (strm.data_en) begin
        n_words++;
        check("word_needs_ready", 32'(prev_ta), 32'd1);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %08h expected no word", strm.data_out);
        end else begin
          check("stream_word", strm.data_out, sb_q.pop_front());
        end
      end
      if (cnt_clear) n_clear++;
      if (cnt_enable) n_cen++;
      if (strm.transfer_en) n_ten++;
      if (ro_enable) n_ro++;
      if (!exp_mode) begin
        if (strm.transfer_en && !ro_enable) low_run++;
        else if (low_run != 0) begin
          check("cooldown_len", 32'(low_run), 32'(exp_cool));
          low_run = 0;
        end
      end
      prev_ta = strm.transfer_active;
    end
  endtask

  task automatic run_meas(input int heat, input int tim, input int rd, input int cool,
                          input bit mode, input bit stall, input int stall_at, input bit scramble);
    int b_clear, b_cen, b_ten, b_ro, b_words, base, cyc, ro_before, tm;
    bit seen_clear, done_seen;
    logic [31:0] tmp;
    tm = (tim == 0) ? 1 : tim;
    exp_cool = cool;
    exp_mode = mode;
    @(posedge CLK); #1;
    meas_cmd = 32'd0;
    strm.transfer_active = 1'b1;
    @(posedge CLK); #1;
    base = clr_n;
    for (int r = 0; r < rd; r++) begin
      if (HDR != 0) sb_q.push_back({8'hA5, 8'(NUM_RO), 16'(r)});
      for (int i = 0; i < NUM_RO; i++) sb_q.push_back({salts[(base + r) % 64], 8'(i)});
    end
    b_clear = n_clear; b_cen = n_cen; b_ten = n_ten; b_ro = n_ro; b_words = n_words;
    meas_heatup = heat; meas_time = tim; meas_readouts = rd; meas_cooldown = cool;
    meas_mode = {31'd0, mode};
    meas_cmd = 32'd1;
    @(negedge CLK);
    check("start_not_before_edge", {30'd0, strm.transfer_en, meas_done}, 32'd0);
    cyc = 0; ro_before = 0; seen_clear = 1'b0; done_seen = 1'b0;
    while (cyc < 3000 && !done_seen) begin
      @(posedge CLK); #1;
      if (stall)
        strm.transfer_active = (cyc >= stall_at && cyc < stall_at + 7) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (scramble && cyc == 0) begin
        tmp = $urandom();
        meas_cmd = {tmp[31:2], 2'b01};
        meas_mode = $urandom();
        meas_time = $urandom_range(0, 30);
        meas_readouts = $urandom_range(0, 9);
        meas_heatup = $urandom_range(0, 9);
        meas_cooldown = $urandom_range(0, 9);
      end
      if (scramble && rd != 0 && cyc == 3) meas_cmd[0] = 1'b0;
      if (scramble && rd != 0 && cyc == 4) meas_cmd[0] = 1'b1;
      @(negedge CLK);
      if (cyc == 0) begin
        check("start_transfer_en", 32'(strm.transfer_en), 32'(rd != 0));
        check("start_done", 32'(meas_done), 32'(rd == 0));
        check("start_ro_enable", 32'(ro_enable), 32'(rd != 0 && (heat != 0 || !mode)));
      end
      if (!seen_clear) begin
        if (cnt_clear) seen_clear = 1'b1;
        else if (ro_enable) ro_before++;
      end
      done_seen = meas_done;
      cyc++;
    end
    check("done_reached", 32'(done_seen), 32'd1);
    @(posedge CLK); #1;
    check("all_words_seen", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    check("clear_pulses", 32'(n_clear - b_clear), 32'(rd));
    check("cnt_enable_cycles", 32'(n_cen - b_cen), 32'(rd * tm));
    check("word_count", 32'(n_words - b_words), 32'(rd * (NUM_RO + HDR)));
    if (rd != 0) check("heatup_ro_cycles", 32'(ro_before), 32'(heat));
    if (!stall)
      check("busy_cycles", 32'(n_ten - b_ten),
            32'((rd == 0) ? 0 : heat + rd * (1 + tm + 2 * (NUM_RO + HDR)) + (rd - 1) * cool));
    if (mode) check("gated_ro_cycles", 32'(n_ro - b_ro), 32'((rd == 0) ? 0 : heat + rd * tm));
    meas_cmd = 32'd0;
    strm.transfer_active = 1'b1;
    @(negedge CLK);
    check("done_holds", 32'(meas_done), 32'd1);
    @(negedge CLK);
    check("done_released", {30'd0, strm.transfer_en, meas_done}, 32'd0);
  endtask

  task automatic abort_run(input bit via_decouple);
    int b_words, bad;
    bit seen;
    exp_cool = 0;
    exp_mode = 1'b0;
    @(posedge CLK); #1;
    meas_cmd = 32'd0;
    strm.transfer_active = 1'b1;
    @(posedge CLK); #1;
    b_words = n_words;
    meas_heatup = 2; meas_time = 40; meas_readouts = 2; meas_cooldown = 0; meas_mode = 0;
    meas_cmd = 32'd1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge CLK);
      seen = cnt_enable;
    end
    check("abort_in_measure", 32'(seen), 32'd1);
    @(posedge CLK); #1;
    if (via_decouple) DECOUPLE = 1'b1;
    else              meas_cmd = 32'h3;
    @(posedge CLK); #1;
    DECOUPLE = 1'b0;
    meas_cmd = 32'd1;
    @(negedge CLK);
    check("abort_outputs", {26'd0, ro_enable, cnt_enable, cnt_clear, strm.data_en, strm.transfer_en, meas_done}, 32'd0);
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (strm.transfer_en || meas_done) bad++;
    end
    check("abort_no_restart", 32'(bad), 32'd0);
    @(posedge CLK); #1;
    check("abort_no_words", 32'(n_words - b_words), 32'd0);
    meas_cmd = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) salts[i] = 24'($urandom());
    RESET = 1'b1; DECOUPLE = 1'b0; meas_cmd = 0; meas_mode = 0; meas_time = 0;
    meas_readouts = 0; meas_heatup = 0; meas_cooldown = 0;
    strm.transfer_active = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ro_enable", 32'(ro_enable), 32'd0);
    check("rst_cnt_clear", 32'(cnt_clear), 32'd0);
    check("rst_cnt_enable", 32'(cnt_enable), 32'd0);
    check("rst_cnt_sel", 32'(cnt_sel), 32'd0);
    check("rst_data_en", 32'(strm.data_en), 32'd0);
    check("rst_data_out", strm.data_out, 32'd0);
    check("rst_transfer_en", 32'(strm.transfer_en), 32'd0);
    check("rst_meas_done", 32'(meas_done), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    fork
      monitor();
    join_none

    run_meas(4, 10, 1, 0, 1'b0, 1'b0, 0, 1'b0);
    run_meas(2, 6, 3, 5, 1'b0, 1'b0, 0, 1'b0);
    run_meas(2, 3, 2, 1, 1'b0, 1'b1, 10, 1'b0);
    abort_run(1'b1);
    abort_run(1'b0);
    run_meas(3, 5, 0, 2, 1'b0, 1'b0, 0, 1'b0);
    run_meas(0, 0, 2, 0, 1'b0, 1'b0, 0, 1'b0);
    run_meas(3, 4, 2, 2, 1'b1, 1'b0, 0, 1'b0);
    for (int k = 0; k < 6; k++)
      run_meas($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(5, 20), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ro_meas_sequencer.md
# ro_meas_sequencer

Measurement sequencer inside the ring-oscillator measurement core. It converts the PS-written measurement registers (command, mode, time, readouts, heat-up, cool-down) into gating signals for the RO array and its counter bank. It then streams every counter value to the PS-side data sink through the `data_en`/`data_out` port, paced by `transfer_active`, and signals completion on `meas_done`.

## Interface
Parameters:
- `NUM_RO`, 32: number of ring oscillators/counters, 1..256.
- `SEL_W`, 8: width of `cnt_sel`; must satisfy 2^SEL_W >= NUM_RO.

Ports:
- `CLK`, in, 1: system clock, sole clock.
- `RESET`, in, 1: asynchronous, active-high reset.
- `DECOUPLE`, in, 1: partial-reconfiguration decouple; forces abort.
- `meas_cmd`, in, 32: bit0 = start (level), bit1 = abort; other bits ignored.
- `meas_mode`, in, 32: bit0 = gated mode (1) / continuous mode (0); other bits ignored.
- `meas_time`, in, 32: count-window length in cycles; 0 is treated as 1.
- `meas_readouts`, in, 32: number of measure/readout rounds; 0 gives immediate done.
- `meas_heatup`, in, 32: heat-up cycles before the first round; 0 skips heat-up.
- `meas_cooldown`, in, 32: cycles between rounds; 0 skips cool-down.
- `ro_enable`, out, 1: enables RO oscillation.
- `cnt_clear`, out, 1: one-cycle synchronous clear of all counters.
- `cnt_enable`, out, 1: counter gate.
- `cnt_sel`, out, SEL_W: counter select for readout.
- `cnt_value`, in, 32: selected counter value, valid one cycle after `cnt_sel`.
- `data_en`, out, 1: `data_out` valid this cycle.
- `data_out`, out, 32: stream word.
- `transfer_en`, out, 1: requests the PS to arm a transfer.
- `transfer_active`, in, 1: PS sink ready; words are emitted only while it is high.
- `meas_done`, out, 1: measurement complete.

## Operation
- All outputs are 0 at reset. The FSM resets to IDLE.
- Start is the rising edge of `meas_cmd[0]`, detected against the registered previous value. On start, all six registers are latched into shadow copies. Register changes after start have no effect on the running measurement.
- States: IDLE, HEATUP, CLEAR, MEASURE, SEL, EMIT, COOLDOWN, DONE.
- IDLE to HEATUP on start:
  - If heat-up = 0, go to CLEAR instead.
  - If readouts = 0, go directly to DONE.
- HEATUP: `ro_enable`=1, `cnt_enable`=0. Lasts exactly the heat-up count, then goes to CLEAR.
- CLEAR: `cnt_clear`=1 for exactly one cycle, then MEASURE.
- MEASURE: `cnt_enable`=1 for exactly max(`meas_time`,1) cycles, then SEL with index = 0.
- SEL: drives `cnt_sel` = index, then goes to EMIT.
- EMIT:
  - Waits for `transfer_active`=1.
  - On that cycle: `data_en`=1 and `data_out` = `cnt_value`.
  - index+1 goes to SEL.
  - After index NUM_RO-1, the round ends.
- Round end:
  - If the round count reached the readouts value, go to DONE.
  - Otherwise go to COOLDOWN, or to CLEAR if cool-down = 0.
- COOLDOWN: `ro_enable`=0 for exactly the cool-down count, then CLEAR.
- `ro_enable` by mode:
  - Continuous mode: 1 in HEATUP, CLEAR, MEASURE, SEL and EMIT.
  - Gated mode: 1 only in HEATUP and MEASURE.
- `transfer_en`: 1 in every state except IDLE and DONE.
- DONE: `meas_done`=1. Holds until `meas_cmd[0]` is low, then returns to IDLE with `meas_done` cleared.
- Abort: `meas_cmd[1]`=1 or `DECOUPLE`=1 in any state.
  - Next cycle: IDLE, with `ro_enable`, `cnt_enable`, `data_en` and `transfer_en` at 0.
  - `meas_done` is not set.
  - A new start requires a fresh rising edge of `meas_cmd[0]`.
- Cycle counters and round counters are 32-bit and never wrap. A value of 0xFFFFFFFF is honoured exactly.

## Timing
- Start to first `ro_enable`: 1 cycle (edge registered, state change on the next edge).
- Word cadence is 2 cycles per word when `transfer_active` is held high: SEL then EMIT.
- One round, unstalled, takes 1 + max(T,1) + 2·NUM_RO cycles.
- `transfer_active` low in EMIT holds `cnt_sel` and the index with no word loss. `cnt_value` is re-sampled every cycle while stalled.
- `data_en` never asserts while `transfer_active`=0.
- `data_en` and `data_out` are registered outputs.
- Abort takes priority over all other transitions on the same cycle.
- A start edge while not in IDLE is ignored.

## Configuration
- `RO_SEQ_HEADER_EN` defined:
  - Each round is preceded by one header word, emitted under the same `transfer_active` rule.
  - Header word = {8'hA5, NUM_RO[7:0], round_index[15:0]}.
  - Adds one EMIT slot per round.
- `RO_SEQ_HEADER_EN` undefined: no header; the stream contains counter values only.

## Test plan
- Heat-up=4, time=10, readouts=1, cool-down=0, NUM_RO=4, `transfer_active`=1 -> `ro_enable` high 4 cycles before the `cnt_clear` pulse; `cnt_enable` high exactly 10 cycles; 4 words for `cnt_sel` 0..3, one every 2 cycles; `meas_done`=1.
- readouts=3, cool-down=5 -> 3 `cnt_clear` pulses; `ro_enable`=0 for exactly 5 cycles between rounds, twice; 12 words total.
- Toggle `transfer_active` low for 7 cycles mid-round -> no `data_en` during the stall; word sequence unchanged, with no loss or duplication.
- `DECOUPLE` pulse during MEASURE -> IDLE next cycle; all outputs 0; `meas_done`=0; holding start high does not restart.
- readouts=0 -> `meas_done` the cycle after IDLE exits; no `cnt_clear`, no words. time=0 -> `cnt_enable` high for 1 cycle.
- With `RO_SEQ_HEADER_EN`, NUM_RO=4, readouts=2 -> words 0xA5040000, 4 counts, 0xA5040001, 4 counts.
